new_usb_nonperiodicsched: RTL and testbench

NEW_USB_NONPERIODICSCHED -- requirements
Module: new_usb_nonperiodicsched

---
 rtl/new_usb_nonperiodicsched.sv | 120 ++++++++++++
 tb/tb_new_usb_nonperiodicsched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/new_usb_nonperiodicsched.sv
// Nonperiodic (control/bulk) ED list scheduler: picks a list, issues one ED service request, waits for completion.
// Optional NEW_USB_CBSR_RATIO_EN: counter-driven control/bulk ratio instead of simple alternation.
module new_usb_nonperiodicsched (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic nonperiodic_en_i,
  input  logic cle_i,
  input  logic ble_i,
  input  logic clf_i,
  input  logic blf_i,
  input  logic counter_overflown_i,
  input  logic counter_is_threshold_i,
  output logic req_valid_o,
  input  logic req_ready_i,
  output logic req_bulk_o,
  output logic req_restart_o,
  output logic req_final_o,
  input  logic done_valid_i,
  input  logic done_last_i,
  input  logic done_td_served_i,
  output logic served_control_td_o,
  output logic served_bulk_td_o,
  output logic clear_clf_o,
  output logic clear_blf_o,
  output logic busy_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0] state_q, state_d;
  logic       ctrl_at_head_q, bulk_at_head_q;
  logic       req_bulk_q, req_restart_q, req_final_q;
  logic       served_ctrl_q, served_bulk_q;
  logic       ctrl_active, bulk_active;
  logic       sel_valid, sel_bulk, sel_final;
  logic       select, handshake, done;

  // A list with its head flag set only has work if the HC marked it filled.
  assign ctrl_active = cle_i && (!ctrl_at_head_q || clf_i);
  assign bulk_active = ble_i && (!bulk_at_head_q || blf_i);
  assign sel_valid   = ctrl_active || bulk_active;

`ifdef NEW_USB_CBSR_RATIO_EN
  assign sel_bulk  = !(ctrl_active && (!counter_overflown_i || !bulk_active));
  assign sel_final = !sel_bulk && counter_is_threshold_i;
`else
  logic prefer_bulk_q;
  logic unused_counter;

  assign unused_counter = counter_overflown_i ^ counter_is_threshold_i;
  assign sel_bulk       = bulk_active && (!ctrl_active || prefer_bulk_q);
  assign sel_final      = 1'b0;

  // Flip preference toward the other list every time a TD actually gets served.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prefer_bulk_q <= 1'b0;
    end else if (done && done_td_served_i) begin
      prefer_bulk_q <= !req_bulk_q;
    end
  end
`endif

  assign select    = (state_q == IDLE) && nonperiodic_en_i && sel_valid;
  assign handshake = (state_q == ISSUE) && req_ready_i;
  assign done      = (state_q == WAIT) && done_valid_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (select)    state_d = ISSUE;
      ISSUE:   if (req_ready_i) state_d = WAIT;
      WAIT:    if (done_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      ctrl_at_head_q <= 1'b1;
      bulk_at_head_q <= 1'b1;
      req_bulk_q     <= 1'b0;
      req_restart_q  <= 1'b0;
      req_final_q    <= 1'b0;
      served_ctrl_q  <= 1'b0;
      served_bulk_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      served_ctrl_q <= done && done_td_served_i && !req_bulk_q;
      served_bulk_q <= done && done_td_served_i && req_bulk_q;
      if (select) begin
        req_bulk_q    <= sel_bulk;
        req_restart_q <= sel_bulk ? bulk_at_head_q : ctrl_at_head_q;
        req_final_q   <= sel_final;
      end
      if (handshake && req_restart_q) begin
        if (req_bulk_q) bulk_at_head_q <= 1'b0;
        else            ctrl_at_head_q <= 1'b0;
      end
      if (done && done_last_i) begin
        if (req_bulk_q) bulk_at_head_q <= 1'b1;
        else            ctrl_at_head_q <= 1'b1;
      end
    end
  end

  assign req_valid_o         = (state_q == ISSUE);
  assign req_bulk_o          = (state_q == ISSUE) ? req_bulk_q    : 1'b0;
  assign req_restart_o       = (state_q == ISSUE) ? req_restart_q : 1'b0;
  assign req_final_o         = (state_q == ISSUE) ? req_final_q   : 1'b0;
  assign clear_clf_o         = handshake && req_restart_q && !req_bulk_q;
  assign clear_blf_o         = handshake && req_restart_q && req_bulk_q;
  assign served_control_td_o = served_ctrl_q;
  assign served_bulk_td_o    = served_bulk_q;
  assign busy_o              = (state_q != IDLE);

endmodule

// File: tb/tb_new_usb_nonperiodicsched.sv
// Scoreboard bench for new_usb_nonperiodicsched: expected requests and served pulses are queued by the driver
// and popped by a negedge monitor.
module tb_new_usb_nonperiodicsched;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic nonperiodic_en_i = 1'b0, cle_i = 1'b0, ble_i = 1'b0, clf_i = 1'b0, blf_i = 1'b0;
  logic counter_overflown_i = 1'b0, counter_is_threshold_i = 1'b0;
  logic req_valid_o, req_ready_i = 1'b0, req_bulk_o, req_restart_o, req_final_o;
  logic done_valid_i = 1'b0, done_last_i = 1'b0, done_td_served_i = 1'b0;
  logic served_control_td_o, served_bulk_td_o, clear_clf_o, clear_blf_o, busy_o;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_req_q[$];
  logic       exp_srv_q[$];
  logic [2:0] mon_req;
  logic       mon_srv;

  always #5 clk_i = ~clk_i;

  new_usb_nonperiodicsched dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .nonperiodic_en_i(nonperiodic_en_i),
    .cle_i(cle_i), .ble_i(ble_i), .clf_i(clf_i), .blf_i(blf_i),
    .counter_overflown_i(counter_overflown_i), .counter_is_threshold_i(counter_is_threshold_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_bulk_o(req_bulk_o),
    .req_restart_o(req_restart_o), .req_final_o(req_final_o),
    .done_valid_i(done_valid_i), .done_last_i(done_last_i), .done_td_served_i(done_td_served_i),
    .served_control_td_o(served_control_td_o), .served_bulk_td_o(served_bulk_td_o),
    .clear_clf_o(clear_clf_o), .clear_blf_o(clear_blf_o), .busy_o(busy_o)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake and every served pulse must match the head of its queue.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (req_valid_o && req_ready_i) begin
        if (exp_req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_unexpected: got bulk=%0b restart=%0b final=%0b expected none",
                   req_bulk_o, req_restart_o, req_final_o);
        end else begin
          mon_req = exp_req_q.pop_front();
          chk("req_fields", 16'({req_bulk_o, req_restart_o, req_final_o}), 16'(mon_req));
          chk("clear_pulse", 16'({clear_clf_o, clear_blf_o}),
              16'({mon_req[1] & ~mon_req[2], mon_req[1] & mon_req[2]}));
        end
      end else if (clear_clf_o || clear_blf_o) begin
        checks++; errors++;
        $display("FAIL clear_stray: got clf=%0b blf=%0b expected 0", clear_clf_o, clear_blf_o);
      end
      if (served_control_td_o || served_bulk_td_o) begin
        if (exp_srv_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL served_unexpected: got ctrl=%0b bulk=%0b expected none",
                   served_control_td_o, served_bulk_td_o);
        end else begin
          mon_srv = exp_srv_q.pop_front();
          chk("served_list", 16'({served_bulk_td_o, served_control_td_o}), 16'({mon_srv, ~mon_srv}));
        end
      end
    end
  end

  task automatic wait_valid(output logic ok);
    int n = 0;
    while (!req_valid_o && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    ok = req_valid_o;
    chk("req_valid_seen", 16'(req_valid_o), 16'(1));
  endtask

  task automatic serve(input logic bulk, input logic restart, input logic fin, input int dly,
                       input logic last, input logic td, input logic drop_en);
    logic ok;
    logic [2:0] snap;
    exp_req_q.push_back({bulk, restart, fin});
    wait_valid(ok);
    if (!ok) begin
      exp_req_q.delete(exp_req_q.size() - 1);
      return;
    end
    if (drop_en) nonperiodic_en_i = 1'b0;
    snap = {req_bulk_o, req_restart_o, req_final_o};
    for (int i = 0; i < dly; i++) begin
      @(posedge clk_i); #1;
      chk("req_hold_valid", 16'(req_valid_o), 16'(1));
      chk("req_hold_fields", 16'({req_bulk_o, req_restart_o, req_final_o}), 16'(snap));
    end
    req_ready_i = 1'b1;
    @(posedge clk_i); #1;
    req_ready_i = 1'b0;
    chk("in_wait", 16'({busy_o, req_valid_o}), 16'(2'b10));
    done_valid_i = 1'b1; done_last_i = last; done_td_served_i = td;
    if (td) exp_srv_q.push_back(bulk);
    @(posedge clk_i); #1;
    done_valid_i = 1'b0; done_last_i = 1'b0; done_td_served_i = 1'b0;
    chk("served_timing", 16'({served_bulk_td_o, served_control_td_o}),
        td ? (bulk ? 16'd2 : 16'd1) : 16'd0);
    chk("idle_after_done", 16'({busy_o, req_valid_o}), 16'(0));
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic ok;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_outputs", 16'({req_valid_o, busy_o, req_bulk_o, req_restart_o, req_final_o,
                              clear_clf_o, clear_blf_o, served_control_td_o, served_bulk_td_o}), 16'(0));
    cle_i = 1'b1; clf_i = 1'b1; nonperiodic_en_i = 1'b1;
    rst_ni = 1'b1;
    chk("no_valid_at_release", 16'(req_valid_o), 16'(0));

    // control from head, then continuing, then end of list with a slow ready
    serve(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    clf_i = 1'b0;
    serve(1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b1, 1'b0);
    // control parked at head and unfilled: only bulk runs
    ble_i = 1'b1; blf_i = 1'b1;
    serve(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    blf_i = 1'b0;
    serve(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    // both lists active
    clf_i = 1'b1;
    serve(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    clf_i = 1'b0;
`ifdef NEW_USB_CBSR_RATIO_EN
    serve(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    serve(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    serve(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    counter_overflown_i = 1'b1;
    serve(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    counter_overflown_i = 1'b0; counter_is_threshold_i = 1'b1;
    serve(1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
`else
    serve(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    serve(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    serve(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    counter_overflown_i = 1'b1;
    serve(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    counter_overflown_i = 1'b0; counter_is_threshold_i = 1'b1;
    serve(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
`endif
    counter_is_threshold_i = 1'b0;

    // window closes mid-request: request completes, then the block stays idle
    serve(1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b1);
    done_valid_i = 1'b1; done_td_served_i = 1'b1;
    @(posedge clk_i); #1;
    done_valid_i = 1'b0; done_td_served_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("idle_window_closed", 16'({busy_o, req_valid_o, served_control_td_o, served_bulk_td_o}), 16'(0));
    nonperiodic_en_i = 1'b1;

    // reset while waiting for completion
`ifdef NEW_USB_CBSR_RATIO_EN
    exp_req_q.push_back(3'b000);
`else
    exp_req_q.push_back(3'b100);
`endif
    wait_valid(ok);
    req_ready_i = 1'b1;
    @(posedge clk_i); #1;
    req_ready_i = 1'b0;
    chk("busy_before_reset", 16'(busy_o), 16'(1));
    rst_ni = 1'b0;
    done_valid_i = 1'b1; done_td_served_i = 1'b1;
    #1;
    chk("reset_mid_wait", 16'({req_valid_o, busy_o, clear_clf_o, clear_blf_o,
                               served_control_td_o, served_bulk_td_o}), 16'(0));
    repeat (3) begin
      @(posedge clk_i); #1;
      chk("no_served_in_reset", 16'({served_control_td_o, served_bulk_td_o, req_valid_o}), 16'(0));
    end
    done_valid_i = 1'b0; done_td_served_i = 1'b0;
    nonperiodic_en_i = 1'b0;
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("idle_after_reset", 16'({busy_o, served_control_td_o, served_bulk_td_o}), 16'(0));

    chk("req_queue_empty", 16'(exp_req_q.size()), 16'(0));
    chk("served_queue_empty", 16'(exp_srv_q.size()), 16'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
